dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-memory bridge between the MEM stage and the data bus. It takes the MEM stage's single-cycle, combinational memory request (ce/we/addr/sel/data) and runs it as a registered cyc/stb/ack bus transaction. While the transaction is outstanding it holds the pipeline with a stall request. It returns the captured read word to the MEM stage's memory-data input.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (sel width = DATA_W/8)
- TIMEOUT_CYCLES, 255, BUSY cycles before abort (macro-gated)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- cpu_ce_i  in  1  request valid, from MEM stage chip enable
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  byte address
- cpu_sel_i  in  4  byte lane select
- cpu_data_i  in  DATA_W  store data
- cpu_data_o  out  DATA_W  load data to MEM stage
- stallreq_o  out  1  pipeline stall request to control
- bus_cyc_o, bus_stb_o  out  1  bus cycle / strobe
- bus_we_o  out  1  bus write enable
- bus_adr_o  out  ADDR_W  bus address
- bus_sel_o  out  4  bus byte select
- bus_dat_o  out  DATA_W  bus write data
- bus_dat_i  in  DATA_W  bus read data
- bus_ack_i  in  1  bus acknowledge
- err_o  out  1  one-cycle abort pulse

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - With cpu_ce_i=1, latch we/addr/sel/data into the bus output registers and set bus_cyc_o=bus_stb_o=1 at the next edge. Go to BUSY.
  - stallreq_o = cpu_ce_i, combinational.
- BUSY:
  - stallreq_o=1.
  - On bus_ack_i=1: clear cyc/stb at the edge and go to DONE.
  - If the access is a load, capture bus_dat_i into cpu_data_o at the same edge.
  - Stores leave cpu_data_o unchanged.
- DONE:
  - stallreq_o=0, so the pipeline advances at the end of this cycle.
  - Unconditionally return to IDLE.
  - cpu_ce_i is ignored here, because it still belongs to the retiring instruction.
- bus_ack_i outside BUSY is ignored.
- Bus address/sel/data/we hold their values from request latch until the next request.
- Reset values:
  - cyc/stb/we = 0.
  - adr/sel/dat_o = 0.
  - cpu_data_o = 0.
  - err_o = 0.
  - State = IDLE. stallreq_o is 0 unless cpu_ce_i=1.
- Reset mid-transaction: state returns to IDLE and cyc/stb drop at that edge. A late ack is ignored.

## Timing
- Cycle 0: request seen in IDLE, stall asserted.
- Cycle 1: stb=1. A zero-wait ack in cycle 1 gives DONE in cycle 2.
- Minimum occupancy is 3 cycles (2 stalled). Each wait state adds 1 cycle.
- Back-to-back accesses: the second request's IDLE cycle immediately follows DONE. There is no overlap.
- cpu_data_o is valid from the DONE cycle until the next load completes.

## Configuration
- DMEM_BRIDGE_TIMEOUT_EN defined:
  - A BUSY-cycle counter clears on BUSY entry.
  - Reaching TIMEOUT_CYCLES without ack aborts the transaction: cyc/stb drop, state goes to DONE, load data is forced to 0, and err_o pulses 1 for the DONE cycle.
  - An ack in the same cycle as the limit wins, with no error.
- DMEM_BRIDGE_TIMEOUT_EN undefined: BUSY waits indefinitely and err_o is tied 0.

## Structure
- Shared constants in defines.v: state encodings (DmemIdle/DmemBusy/DmemDone), ChipEnable/WriteEnable reuse, and the default timeout.
- One sub-module, dmem_bridge_wdog (counter + compare, emits timeout). It is instantiated only under the macro.

## Test plan
- Zero-wait load: ce=1, we=0, addr=0x100, ack in stb cycle, bus_dat_i=0x12345678 -> stall high for 2 cycles, cpu_data_o=0x12345678 in cycle 2, stall low.
- Store with 3 wait states: addr=0x204, sel=4'b0011, data=0xA5A5 -> bus_we_o=1, adr/sel/dat stable, stall high for 5 cycles, cpu_data_o unchanged.
- Back-to-back load then store -> a second stb rises the cycle after DONE, and no ack is double-counted.
- Reset asserted in BUSY, ack arrives the next cycle -> cyc/stb 0 after the reset edge, state IDLE, cpu_data_o=0.
- Macro on, TIMEOUT_CYCLES=4, no ack -> abort after 4 BUSY cycles, err_o=1 for one cycle, cpu_data_o=0, stall released.
- Macro on, ack exactly on the 4th BUSY cycle -> normal completion, err_o stays 0.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge: FSM state encodings,
// chip/write enable polarities and the default BUSY timeout.
package dmem_bridge_pkg;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        DmemIdle = 2'd0,
        DmemBusy = 2'd1,
        DmemDone = 2'd2
    } dmem_state_e;

    // Active levels of the MEM stage's chip enable and write enable.
    localparam logic ChipEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

    // BUSY cycles allowed before the watchdog aborts an access.
    localparam int unsigned DefaultTimeout = 255;

    // Width of a counter that must hold the values 0 .. limit-1.
    function automatic int unsigned wdog_cnt_width(input int unsigned limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Data-bus interface of the bridge: cyc/stb/ack handshake plus the
// address, byte-select and the two data directions.
interface dmem_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat_w;   // bridge -> memory (store data)
    logic [DATA_W-1:0] dat_r;   // memory -> bridge (load data)
    logic              ack;

    // The bridge starts transactions.
    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack
    );

    // The memory answers them.
    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack
    );

endinterface

// File: rtl/dmem_bridge_wdog.sv
// BUSY-cycle watchdog for the data-memory bridge. The counter clears when
// a transaction enters BUSY and flags timeout during the LIMIT-th BUSY cycle.
// Only instantiated when DMEM_BRIDGE_TIMEOUT_EN is defined.
module dmem_bridge_wdog
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = DefaultTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic start,     // transaction is entering BUSY at the next edge
    input  logic busy,      // FSM is in BUSY this cycle
    output logic timeout    // this BUSY cycle is the last one allowed
);

    localparam int unsigned CNT_W = wdog_cnt_width(LIMIT);

    // Number of BUSY cycles already completed for the current access.
    logic [CNT_W-1:0] busy_cnt;

    assign timeout = busy && (busy_cnt == CNT_W'(LIMIT - 1));

    // Count BUSY cycles, restarting from zero on every new access.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (start) begin
            busy_cnt <= '0;
        end else if (busy && !timeout) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the MEM stage's combinational request into a
// registered cyc/stb/ack bus transaction, stalls the pipeline while it is
// outstanding and returns the captured load word.
// Optional feature: define DMEM_BRIDGE_TIMEOUT_EN to abort accesses that
// see no ack within TIMEOUT_CYCLES BUSY cycles (err_o pulses on abort).
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
    input  logic                clk,
    input  logic                rst,

    // MEM stage side
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic                err_o,

    // Data bus side
    dmem_bridge_if.master       bus
);

    dmem_state_e state;
    dmem_state_e state_next;

    logic req_latch;   // IDLE accepts a request at this edge
    logic bus_done;    // BUSY sees ack at this edge
    logic abort;       // BUSY gives up at this edge (watchdog)
    logic timeout;     // watchdog limit reached in this BUSY cycle

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    dmem_bridge_wdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .start   (req_latch),
        .busy    (state == DmemBusy),
        .timeout (timeout)
    );
`else
    // Without the watchdog BUSY waits for ack indefinitely; the limit
    // parameter is kept so both builds share one parameter list.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DmemIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, stall request and datapath strobes.
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        stallreq_o = 1'b0;
        req_latch  = 1'b0;
        bus_done   = 1'b0;
        abort      = 1'b0;

        case (state)
            DmemIdle: begin
                // The stall must be raised in the same cycle the request appears.
                stallreq_o = cpu_ce_i;
                if (cpu_ce_i == ChipEnable) begin
                    req_latch  = 1'b1;
                    state_next = DmemBusy;
                end
            end

            DmemBusy: begin
                stallreq_o = 1'b1;
                // An ack in the limit cycle completes normally.
                if (bus.ack) begin
                    bus_done   = 1'b1;
                    state_next = DmemDone;
                end else if (timeout) begin
                    abort      = 1'b1;
                    state_next = DmemDone;
                end
            end

            DmemDone: begin
                // Stall released so the retiring instruction leaves MEM;
                // its still-asserted ce must not start a second access.
                state_next = DmemIdle;
            end

            default: begin
                state_next = DmemIdle;
            end
        endcase
    end

    // Bus request registers: latched on acceptance, held until the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cyc   <= 1'b0;
            bus.stb   <= 1'b0;
            bus.we    <= 1'b0;
            bus.adr   <= '0;
            bus.sel   <= '0;
            bus.dat_w <= '0;
        end else if (req_latch) begin
            bus.cyc   <= 1'b1;
            bus.stb   <= 1'b1;
            bus.we    <= cpu_we_i;
            bus.adr   <= cpu_addr_i;
            bus.sel   <= cpu_sel_i;
            bus.dat_w <= cpu_data_i;
        end else if (bus_done || abort) begin
            bus.cyc   <= 1'b0;
            bus.stb   <= 1'b0;
        end
    end

    // Load data returned to MEM: captured on ack, zeroed by an aborted load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_data_o <= '0;
        end else if (bus_done && (bus.we != WriteEnable)) begin
            cpu_data_o <= bus.dat_r;
        end else if (abort && (bus.we != WriteEnable)) begin
            cpu_data_o <= '0;
        end
    end

    // Error pulse: high for exactly the DONE cycle that follows an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= abort;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge. The bench plays both the MEM stage
// and a word-addressed memory with a programmable number of wait states.
// Expected load data, store effects and stall lengths come from a simple
// memory model and the cycle-occupancy rule (2 stalled cycles + waits).
// Define DMEM_BRIDGE_TIMEOUT_EN to also exercise the watchdog (limit 4).
module tb_dmem_bridge;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_rdata;
    logic [31:0] mem [int unsigned];

    dmem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    dmem_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce),
        .cpu_we_i   (cpu_we),
        .cpu_addr_i (cpu_addr),
        .cpu_sel_i  (cpu_sel),
        .cpu_data_i (cpu_wdata),
        .cpu_data_o (cpu_rdata),
        .stallreq_o (stall),
        .err_o      (err),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    // Word stored at a byte address; untouched words read as an address hash.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a >> 2)) return mem[a >> 2];
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    // Apply a store with byte-lane enables to the memory model.
    task automatic mem_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem[a >> 2] = w;
    endtask

    // One complete access starting at a negedge in IDLE. The memory acks in
    // BUSY cycle number 'waits' (0 = zero-wait). With stray_ack the ack stays
    // high through DONE; with next_b2b the ce is left high for the caller.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] data, input int waits, input bit stray_ack,
                              input bit next_b2b, input string tag);
        int          stall_seen;
        logic [31:0] rd;
        stall_seen = 0;
        bus_if.ack = 1'b0;
        cpu_ce     = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_sel    = sel;
        cpu_wdata  = data;
        #1;
        // Request cycle: stall combinational, strobe not yet up.
        if (stall === 1'b1) stall_seen++;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL %s req_stall got=%b exp=1", tag, stall);
        end
        n_cmp++;
        if (bus_if.stb !== 1'b0) begin
            n_bad++;
            $display("FAIL %s req_stb got=%b exp=0", tag, bus_if.stb);
        end
        rd = we ? $urandom : mem_read(addr);
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (stall === 1'b1) stall_seen++;
            n_cmp++;
            if ({bus_if.cyc, bus_if.stb, bus_if.we} !== {2'b11, we}) begin
                n_bad++;
                $display("FAIL %s busy_ctl k=%0d got=%b exp=%b", tag, k,
                         {bus_if.cyc, bus_if.stb, bus_if.we}, {2'b11, we});
            end
            n_cmp++;
            if ({bus_if.adr, bus_if.sel, bus_if.dat_w} !== {addr, sel, data}) begin
                n_bad++;
                $display("FAIL %s busy_req k=%0d got=%h/%h/%h exp=%h/%h/%h", tag, k,
                         bus_if.adr, bus_if.sel, bus_if.dat_w, addr, sel, data);
            end
            if (k == waits) begin
                bus_if.ack   = 1'b1;
                bus_if.dat_r = rd;
            end else begin
                bus_if.dat_r = $urandom;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (!stray_ack) bus_if.ack = 1'b0;
        if (we) mem_write(addr, sel, data);
        else exp_rdata = rd;
        // DONE cycle.
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_stall got=%b exp=0", tag, stall);
        end
        n_cmp++;
        if ({bus_if.cyc, bus_if.stb} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s done_cycstb got=%b exp=00", tag, {bus_if.cyc, bus_if.stb});
        end
        n_cmp++;
        if (cpu_rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL %s done_rdata got=%h exp=%h", tag, cpu_rdata, exp_rdata);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_err got=%b exp=0", tag, err);
        end
        n_cmp++;
        if ({bus_if.adr, bus_if.sel, bus_if.dat_w, bus_if.we} !== {addr, sel, data, we}) begin
            n_bad++;
            $display("FAIL %s done_hold got=%h/%h/%h exp=%h/%h/%h", tag,
                     bus_if.adr, bus_if.sel, bus_if.dat_w, addr, sel, data);
        end
        n_cmp++;
        if (stall_seen !== waits + 2) begin
            n_bad++;
            $display("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_seen, waits + 2);
        end
        // ce stays high through DONE; the next cycle must be a plain IDLE.
        @(posedge clk);
        @(negedge clk);
        bus_if.ack = 1'b0;
        if (!next_b2b) begin
            cpu_ce = 1'b0;
            #1;
            n_cmp++;
            if ({bus_if.cyc, stall} !== 2'b00) begin
                n_bad++;
                $display("FAIL %s idle_after got=%b exp=00", tag, {bus_if.cyc, stall});
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        cpu_ce       = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = '0;
        cpu_sel      = '0;
        cpu_wdata    = '0;
        bus_if.ack   = 1'b0;
        bus_if.dat_r = '0;
        exp_rdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus_if.cyc, bus_if.stb, bus_if.we, stall, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b exp=00000",
                     {bus_if.cyc, bus_if.stb, bus_if.we, stall, err});
        end
        n_cmp++;
        if ({bus_if.adr, bus_if.sel, bus_if.dat_w, cpu_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus_if.adr, bus_if.sel,
                     bus_if.dat_w, cpu_rdata);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cpu_ce = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle_stall got=%b exp=1", stall);
        end
        cpu_ce = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_nostall got=%b exp=0", stall);
        end
    endtask

    task automatic test_zero_wait_load();
        mem[32'h100 >> 2] = 32'h1234_5678;
        run_access(1'b0, 32'h100, 4'hF, 32'h0, 0, 1'b0, 1'b0, "zw_load");
    endtask

    task automatic test_store_wait3();
        run_access(1'b1, 32'h204, 4'b0011, 32'h0000_A5A5, 3, 1'b0, 1'b0, "st_w3");
    endtask

    task automatic test_back_to_back();
        run_access(1'b0, 32'h208, 4'hF, 32'h0, 1, 1'b1, 1'b1, "b2b_load");
        run_access(1'b1, 32'h20C, 4'b1100, 32'hDEAD_BEEF, 0, 1'b1, 1'b0, "b2b_store");
    endtask

    task automatic test_stray_ack();
        bus_if.ack   = 1'b1;
        bus_if.dat_r = 32'hFFFF_0000;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({bus_if.cyc, bus_if.stb, stall, err} !== 4'b0 || cpu_rdata !== exp_rdata) begin
                n_bad++;
                $display("FAIL stray_ack got=%b/%h exp=0000/%h",
                         {bus_if.cyc, bus_if.stb, stall, err}, cpu_rdata, exp_rdata);
            end
        end
        bus_if.ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        cpu_ce   = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h400;
        cpu_sel  = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        cpu_ce = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b0;
        bus_if.ack   = 1'b1;
        bus_if.dat_r = 32'h7777_1111;
        exp_rdata    = '0;
        n_cmp++;
        if ({bus_if.cyc, bus_if.stb, stall} !== 3'b000 || cpu_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_edge got=%b/%h exp=000/0",
                     {bus_if.cyc, bus_if.stb, stall}, cpu_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        bus_if.ack = 1'b0;
        n_cmp++;
        if ({bus_if.cyc, bus_if.stb, stall, err} !== 4'b0 || cpu_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_late_ack got=%b/%h exp=0000/0",
                     {bus_if.cyc, bus_if.stb, stall, err}, cpu_rdata);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        bit          b2b;
        for (int i = 0; i < 40; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
            sel  = 4'($urandom_range(1, 15));
            b2b  = (i != 39) && ($urandom_range(0, 1) == 1);
            run_access(we, addr, sel, $urandom, int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), b2b, "rand");
        end
    endtask

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        cpu_ce     = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h300;
        cpu_sel    = 4'hF;
        bus_if.ack = 1'b0;
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({stall, bus_if.cyc, err} !== 3'b110) begin
                n_bad++;
                $display("FAIL to_busy k=%0d got=%b exp=110", k, {stall, bus_if.cyc, err});
            end
        end
        @(posedge clk);
        @(negedge clk);
        exp_rdata = '0;
        n_cmp++;
        if ({stall, bus_if.cyc, bus_if.stb, err} !== 4'b0001 || cpu_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL to_abort got=%b/%h exp=0001/0",
                     {stall, bus_if.cyc, bus_if.stb, err}, cpu_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        cpu_ce = 1'b0;
        #1;
        n_cmp++;
        if ({stall, bus_if.cyc, err} !== 3'b000) begin
            n_bad++;
            $display("FAIL to_after got=%b exp=000", {stall, bus_if.cyc, err});
        end
    endtask

    task automatic test_ack_at_limit();
        run_access(1'b0, 32'h304, 4'hF, 32'h0, TB_TIMEOUT - 1, 1'b0, 1'b0, "ack_limit");
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait3();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid();
        test_random();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        test_timeout();
        test_ack_at_limit();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #1_000_000;
        $display("FAIL time_limit got=expired exp=finished");
        $fatal(1, "time limit");
    end

endmodule
